// File: rtl/fsm6_step_ctrl.sv
// fsm6_step_ctrl
//   Six-state symbol-stepping controller. Each accepted step moves the state
//   machine along the w=0 or w=1 arc. A configuration master can force any
//   legal state with a load. The block also counts how many times the machine
//   enters the z region (E or F).
//
// Ports
//   clk         rising-edge clock
//   resetn      asynchronous, active-low reset
//   in_valid    requester presents a step symbol on w
//   w           step symbol, sampled only on an accepted step
//   in_ready    a step can be accepted this cycle (low while load is asserted)
//   load        force-state request; has priority over a step
//   load_state  target state code for load (110/111 are illegal)
//   clr_count   synchronous clear of z_count
//   state       current registered state code
//   z           high in states E and F
//   z_count     saturating count of entries into {E,F}
//   err         one-cycle pulse following an illegal load
//
// state | meaning
// ------+------------------------------------------
// A 000 | idle / reset state
// B 001 | one w=0 seen from A
// C 010 | two zeros (or F re-entered on w=0)
// D 011 | w=1 branch
// E 100 | z region, reached from C or held on w=0
// F 101 | z region, reached from D on w=0

module fsm6_step_ctrl (
   input  logic       clk,
   input  logic       resetn,
   input  logic       in_valid,
   input  logic       w,
   output logic       in_ready,
   input  logic       load,
   input  logic [2:0] load_state,
   input  logic       clr_count,
   output logic [2:0] state,
   output logic       z,
   output logic [7:0] z_count,
   output logic       err
);

   typedef enum logic [2:0] {
      ST_A = 3'b000,
      ST_B = 3'b001,
      ST_C = 3'b010,
      ST_D = 3'b011,
      ST_E = 3'b100,
      ST_F = 3'b101
   } state_t;

   state_t     state_q;
   state_t     state_nxt;
   logic       err_nxt;
   logic       z_entry;
   logic [7:0] z_count_q;
   logic       err_q;

   function automatic logic in_z_region(input state_t s);
      return (s == ST_E) || (s == ST_F);
   endfunction

   assign in_ready = ~load;

   always_comb begin
      state_nxt = state_q;
      err_nxt   = 1'b0;
      if (load) begin
         if (load_state <= 3'b101) begin
            state_nxt = state_t'(load_state);
         end else begin
            state_nxt = ST_A;
            err_nxt   = 1'b1;
         end
      end else if (in_valid) begin
         case (state_q)
            ST_A:    state_nxt = w ? ST_A : ST_B;
            ST_B:    state_nxt = w ? ST_D : ST_C;
            ST_C:    state_nxt = w ? ST_D : ST_E;
            ST_D:    state_nxt = w ? ST_A : ST_F;
            ST_E:    state_nxt = w ? ST_D : ST_E;
            ST_F:    state_nxt = w ? ST_D : ST_C;
            default: state_nxt = ST_A;
         endcase
      end
   end

   // Only crossings from {A..D} into {E,F} count. Moves inside the region
   // (E->E, E->F, F->E) do not.
   assign z_entry = ~in_z_region(state_q) & in_z_region(state_nxt);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= ST_A;
         err_q     <= 1'b0;
         z_count_q <= 8'd0;
      end else begin
         state_q <= state_nxt;
         err_q   <= err_nxt;
         if (clr_count)
            z_count_q <= 8'd0;
         else if (z_entry && (z_count_q != 8'hFF))
            z_count_q <= z_count_q + 8'd1;
      end
   end

   assign state   = state_q;
   assign z       = in_z_region(state_q);
   assign z_count = z_count_q;
   assign err     = err_q;

endmodule

// File: tb/tb_fsm6_step_ctrl.sv
module tb_fsm6_step_ctrl;

   logic       clk = 1'b0;
   logic       resetn;
   logic       in_valid;
   logic       w;
   logic       in_ready;
   logic       load;
   logic [2:0] load_state;
   logic       clr_count;
   logic [2:0] state;
   logic       z;
   logic [7:0] z_count;
   logic       err;

   int checks = 0;
   int errors = 0;

   localparam logic [2:0] A = 3'b000, B = 3'b001, C = 3'b010,
                          D = 3'b011, E = 3'b100, F = 3'b101;

   fsm6_step_ctrl dut (
      .clk        (clk),
      .resetn     (resetn),
      .in_valid   (in_valid),
      .w          (w),
      .in_ready   (in_ready),
      .load       (load),
      .load_state (load_state),
      .clr_count  (clr_count),
      .state      (state),
      .z          (z),
      .z_count    (z_count),
      .err        (err)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // full output snapshot
   task automatic chk_all(input string tag, input logic [2:0] s, input logic zz,
                          input logic [7:0] cnt, input logic e);
      chk({tag, ".state"},   {5'd0, state}, {5'd0, s});
      chk({tag, ".z"},       {7'd0, z},     {7'd0, zz});
      chk({tag, ".z_count"}, z_count,       cnt);
      chk({tag, ".err"},     {7'd0, err},   {7'd0, e});
   endtask

   // Inputs change at negedge; outputs are sampled at the following negedge.
   task automatic step(input logic wv);
      in_valid = 1'b1;
      w        = wv;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      w        = 1'b0;
   endtask

   task automatic do_load(input logic [2:0] s, input logic iv, input logic wv);
      load       = 1'b1;
      load_state = s;
      in_valid   = iv;
      w          = wv;
      #1;
      chk("load.in_ready", {7'd0, in_ready}, 8'd0);
      @(posedge clk);
      @(negedge clk);
      load     = 1'b0;
      in_valid = 1'b0;
      w        = 1'b0;
   endtask

   task automatic idle();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      resetn     = 1'b0;
      in_valid   = 1'b0;
      w          = 1'b0;
      load       = 1'b0;
      load_state = 3'b000;
      clr_count  = 1'b0;

      // reset state and in_ready following load during reset
      #1;
      chk_all("rst", A, 1'b0, 8'd0, 1'b0);
      chk("rst.in_ready1", {7'd0, in_ready}, 8'd1);
      load = 1'b1;
      #1;
      chk("rst.in_ready0", {7'd0, in_ready}, 8'd0);
      load = 1'b0;
      @(negedge clk);
      @(negedge clk);
      resetn = 1'b1;

      // A->B->C->E; the step on the first edge after release is accepted
      step(1'b0); chk_all("s1", B, 1'b0, 8'd0, 1'b0);
      step(1'b0); chk_all("s2", C, 1'b0, 8'd0, 1'b0);
      step(1'b0); chk_all("s3", E, 1'b1, 8'd1, 1'b0);

      // from E: 0,1,0,0 -> E,D,F,C
      step(1'b0); chk_all("e1", E, 1'b1, 8'd1, 1'b0);
      step(1'b1); chk_all("e2", D, 1'b0, 8'd1, 1'b0);
      step(1'b0); chk_all("e3", F, 1'b1, 8'd2, 1'b0);
      step(1'b0); chk_all("e4", C, 1'b0, 8'd2, 1'b0);

      // no step, no load: state holds
      idle(); chk_all("hold", C, 1'b0, 8'd2, 1'b0);

      // clr_count together with a C->E step
      clr_count = 1'b1;
      step(1'b0);
      clr_count = 1'b0;
      chk_all("clr_step", E, 1'b1, 8'd0, 1'b0);

      // illegal load 110 with in_valid high: A, err for one cycle
      do_load(3'b110, 1'b1, 1'b1); chk_all("ill1", A, 1'b0, 8'd0, 1'b1);
      idle();                      chk_all("ill1b", A, 1'b0, 8'd0, 1'b0);

      // back-to-back illegal loads keep err high
      do_load(3'b111, 1'b0, 1'b0); chk_all("ill2", A, 1'b0, 8'd0, 1'b1);
      do_load(3'b110, 1'b0, 1'b0); chk_all("ill3", A, 1'b0, 8'd0, 1'b1);
      idle();                      chk_all("ill3b", A, 1'b0, 8'd0, 1'b0);

      // legal load into F counts an entry
      do_load(F, 1'b0, 1'b0); chk_all("ldF", F, 1'b1, 8'd1, 1'b0);
      // load wins over a step offered in the same cycle (D, not F)
      do_load(D, 1'b1, 1'b0); chk_all("ldD", D, 1'b0, 8'd1, 1'b0);

      // saturation: 256 more D->F entries starting from 1
      for (int k = 1; k <= 256; k++) begin
         step(1'b0);
         if (k == 253) chk("sat254", z_count, 8'd254);
         if (k == 254) chk("sat255", z_count, 8'd255);
         step(1'b1);
      end
      chk_all("sat_end", D, 1'b0, 8'd255, 1'b0);
      step(1'b0); chk_all("sat_more", F, 1'b1, 8'd255, 1'b0);
      step(1'b1);

      // clr_count alone: state and err untouched
      clr_count = 1'b1;
      idle();
      clr_count = 1'b0;
      chk_all("clr_only", D, 1'b0, 8'd0, 1'b0);

      // loads E then F: only the D->E crossing counts
      do_load(E, 1'b0, 1'b0); chk_all("ldE", E, 1'b1, 8'd1, 1'b0);
      do_load(F, 1'b0, 1'b0); chk_all("ldEF", F, 1'b1, 8'd1, 1'b0);
      step(1'b0);             chk_all("FC", C, 1'b0, 8'd1, 1'b0);

      // reach F with z_count = 5, then async reset between edges
      clr_count = 1'b1;
      do_load(D, 1'b0, 1'b0);
      clr_count = 1'b0;
      chk_all("pre5", D, 1'b0, 8'd0, 1'b0);
      for (int k = 0; k < 4; k++) begin
         step(1'b0);
         step(1'b1);
      end
      step(1'b0);
      chk_all("f5", F, 1'b1, 8'd5, 1'b0);
      #2;
      resetn = 1'b0;
      #1;
      chk_all("async_rst", A, 1'b0, 8'd0, 1'b0);

      // step offered while in reset is not applied
      in_valid = 1'b1;
      w        = 1'b0;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      chk_all("rst_step", A, 1'b0, 8'd0, 1'b0);
      resetn = 1'b1;
      step(1'b1); chk_all("post_a", A, 1'b0, 8'd0, 1'b0);
      step(1'b0); chk_all("post_b", B, 1'b0, 8'd0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fsm6_step_ctrl.md
FSM6_STEP_CTRL -- requirements
Module: fsm6_step_ctrl

Interface
REQ-001 SHALL have no parameters; all widths are fixed as listed below.
REQ-002 SHALL have port `clk`, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port `resetn`, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port `in_valid`, input, 1 bit: the requester presents a `w` symbol.
REQ-005 SHALL have port `w`, input, 1 bit: transition symbol, sampled only on an accepted step.
REQ-006 SHALL have port `in_ready`, output, 1 bit: the block can accept a step this cycle.
REQ-007 SHALL have port `load`, input, 1 bit: force-state request from the configuration master.
REQ-008 SHALL have port `load_state`, input, 3 bits: target state code for `load`.
REQ-009 SHALL have port `clr_count`, input, 1 bit: synchronous clear of `z_count`.
REQ-010 SHALL have port `state`, output, 3 bits: current registered state code.
REQ-011 SHALL have port `z`, output, 1 bit: Moore output.
REQ-012 SHALL have port `z_count`, output, 8 bits: saturating count of z-region entries.
REQ-013 SHALL have port `err`, output, 1 bit: one-cycle pulse on an illegal load.

Function
REQ-014 SHALL encode the states as A=000, B=001, C=010, D=011, E=100 and F=101; codes 110 and 111 are illegal.
REQ-015 SHALL apply these transitions on an accepted step (w=0 / w=1):
- A: B / A
- B: C / D
- C: E / D
- D: F / A
- E: E / D
- F: C / D
REQ-016 SHALL define an accepted step as `in_valid & in_ready` at a rising clock edge; `state` updates on that edge, giving one-cycle latency.
REQ-017 SHALL drive `in_ready = ~load`, combinationally.
REQ-018 SHALL keep `state` unchanged in cycles with no accepted step and no load.
REQ-019 SHALL give `load` priority over any step; a step offered in a `load` cycle is not accepted.
REQ-020 SHALL handle a legal `load` (`load_state` <= 101) by setting `state` to `load_state` on the next edge.
REQ-021 SHALL handle an illegal `load` (110 or 111) by setting `state` to A and setting `err` to 1 for exactly the following cycle.
REQ-022 SHALL clear `err` to 0 in every cycle not immediately following an illegal load; back-to-back illegal loads hold `err` high continuously.
REQ-023 SHALL drive `z` = 1 exactly when `state` is E or F, as a decode of the registered state.
REQ-024 SHALL increment `z_count` by 1 when an accepted step or a load moves `state` from {A,B,C,D} into {E,F}.
REQ-025 SHALL NOT increment `z_count` on E->E, E->F or F->E moves.
REQ-026 SHALL saturate `z_count` at 255: an increment at 255 leaves it at 255, with no wrap.
REQ-027 SHALL make `clr_count` set `z_count` to 0 on the next edge; `clr_count` wins over a simultaneous increment, giving a result of 0.
REQ-028 SHALL make `clr_count` have no effect on `state`, `z` or `err`.
REQ-029 SHALL leave `state` at its reset value if `resetn` is asserted mid-step or mid-load; no partial update is permitted.

Reset
REQ-030 SHALL, while `resetn` = 0, immediately and without waiting for a clock edge, force `state` = A (000), `z` = 0, `z_count` = 0 and `err` = 0.
REQ-031 SHALL drive `in_ready` from `load` only, so it remains valid during reset.
REQ-032 SHALL resume normal operation on the first rising edge after `resetn` deasserts; a step presented on that edge is accepted.

Verification
REQ-033 SHALL pass this directed scenario: after reset, step w = 0,0,0 -> `state` goes A->B->C->E, `z` = 1 after the third edge, `z_count` = 1.
REQ-034 SHALL pass this directed scenario: from E, step w = 0,1,0,0 -> E,D,F,C with `z` = 1,0,1,0, and `z_count` increments only on D->F, reaching 2.
REQ-035 SHALL pass this directed scenario: `load` = 1 with `load_state` = 110 and `in_valid` = 1 -> `in_ready` = 0, `state` = A, and `err` is high for exactly 1 cycle.
REQ-036 SHALL pass this directed scenario: drive 256 D->F entries (via D --w=0--> F, then F --w=1--> D) -> `z_count` = 255, and it stays 255 after further entries.
REQ-037 SHALL pass this directed scenario: `clr_count` asserted in the same cycle as a C->E step -> `state` = E, `z_count` = 0.
REQ-038 SHALL pass this directed scenario: `resetn` pulled low between clock edges while in F with `z_count` = 5 -> `state` = A and `z_count` = 0 before the next edge.
